// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: shares one fixed-latency memory between instruction fetch and data.
// Ties alternate via a last-grant bit; each transfer runs IDLE -> BUSY (LAT cycles) -> RESP.
module mem_arbiter #(
  parameter int unsigned LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  localparam logic [3:0] CntInit = 4'(LAT - 1);

  state_e     state;
  logic [3:0] cnt;
  logic       owner;       // 0 = fetch, 1 = data
  logic       last_grant;  // 0 = fetch, 1 = data
  logic       grant_data;

  // Data wins when it is alone, or on a tie when fetch was granted last.
  assign grant_data = d_req & ~(if_req & last_grant);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= StIdle;
      cnt        <= 4'd0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      if_rdata   <= 32'd0;
      d_rdata    <= 32'd0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
    end else begin
      unique case (state)
        StIdle: begin
          if (if_req || d_req) begin
            state      <= StBusy;
            cnt        <= CntInit;
            owner      <= grant_data;
            last_grant <= grant_data;
            mem_en     <= 1'b1;
            mem_we     <= grant_data & d_we;
            mem_addr   <= grant_data ? d_addr : if_addr;
            mem_wdata  <= grant_data ? d_wdata : 32'd0;
          end
        end
        StBusy: begin
          if (cnt == 4'd0) begin
            state  <= StResp;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            // mem_we still holds the latched direction of this transfer.
            if (!mem_we) begin
              if (owner) d_rdata <= mem_rdata;
              else       if_rdata <= mem_rdata;
            end
            if (owner) d_ack <= 1'b1;
            else       if_ack <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        StResp: begin
          state  <= StIdle;
          if_ack <= 1'b0;
          d_ack  <= 1'b0;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-schedule model checked every cycle, plus directed
// literal expectations for the main scenarios.
module tb_mem_arbiter;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_ack, d_ack, mem_en, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  int          cyc = 0;
  int          n_vec = 0;
  int          n_miss = 0;
  bit          vary;
  logic [31:0] rd_fixed;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory read data: fixed for literal tests, or changing every cycle to expose capture timing.
  assign mem_rdata = vary ? (32'hA500_0000 + 32'(cyc) * 32'h0000_0101) : rd_fixed;

  mem_arbiter #(.LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Schedule model: a request seen in idle cycle c occupies memory c+1..c+LAT,
  // acks in c+LAT+1, and the next arbitration happens in c+LAT+2.
  int          free_cyc, en_from, en_to, ack_cyc;
  bit          own, m_we, lg, e_en, pick_d;
  logic [31:0] m_addr, m_wdata, e_if_rd, e_d_rd;

  always @(negedge clk) begin
    if (!rst) begin
      free_cyc = cyc + 1;
      en_from  = -10;
      en_to    = -10;
      ack_cyc  = -10;
      lg       = 1'b1;
      e_if_rd  = 32'd0;
      e_d_rd   = 32'd0;
      check("rst mem_en", mem_en, 0);
      check("rst mem_we", mem_we, 0);
      check("rst mem_addr", mem_addr, 0);
      check("rst mem_wdata", mem_wdata, 0);
      check("rst if_ack", if_ack, 0);
      check("rst d_ack", d_ack, 0);
      check("rst if_rdata", if_rdata, 0);
      check("rst d_rdata", d_rdata, 0);
    end else begin
      e_en = (cyc >= en_from) && (cyc <= en_to);
      check("mem_en", mem_en, e_en);
      check("mem_we", mem_we, e_en & m_we);
      if (e_en) check("mem_addr", mem_addr, m_addr);
      if (e_en && m_we) check("mem_wdata", mem_wdata, m_wdata);
      check("if_ack", if_ack, (cyc == ack_cyc) && !own);
      check("d_ack", d_ack, (cyc == ack_cyc) && own);
      check("if_rdata", if_rdata, e_if_rd);
      check("d_rdata", d_rdata, e_d_rd);
      if (cyc == en_to && !m_we) begin
        if (own) e_d_rd = mem_rdata;
        else     e_if_rd = mem_rdata;
      end
      if (cyc == free_cyc) begin
        if (if_req || d_req) begin
          if (if_req && d_req) pick_d = (lg == 1'b0);
          else                 pick_d = d_req;
          lg       = pick_d;
          own      = pick_d;
          m_we     = pick_d ? d_we : 1'b0;
          m_addr   = pick_d ? d_addr : if_addr;
          m_wdata  = d_wdata;
          en_from  = cyc + 1;
          en_to    = cyc + int'(LAT);
          ack_cyc  = cyc + int'(LAT) + 1;
          free_cyc = cyc + int'(LAT) + 2;
        end else begin
          free_cyc = cyc + 1;
        end
      end
    end
  end

  // Ack log for ordering checks.
  int ack_cyc_q[$];
  bit ack_port_q[$];
  always @(negedge clk) begin
    if (rst && if_ack) begin ack_cyc_q.push_back(cyc); ack_port_q.push_back(1'b0); end
    if (rst && d_ack)  begin ack_cyc_q.push_back(cyc); ack_port_q.push_back(1'b1); end
  end

  task automatic wait_ack(input bit is_d, output int at);
    at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((is_d ? d_ack : if_ack) === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL ack timeout port=%0d at cycle %0d: got none expected ack", is_d, cyc);
    end
  endtask

  task automatic contend(input int n);
    ack_cyc_q.delete();
    ack_port_q.delete();
    if_req = 1'b1;
    d_req  = 1'b1;
    for (int i = 0; i < n * 6 + 10; i++) begin
      @(posedge clk);
      if (ack_port_q.size() >= n) break;
    end
    #1;
    if_req = 1'b0;
    d_req  = 1'b0;
    check("contend ack count", ack_port_q.size(), n);
  endtask

  int t0, at;
  bit exp_order [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0;
    vary = 1'b0; rd_fixed = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Fetch at 0x100
    @(posedge clk); #1;
    rd_fixed = 32'hE3A0_0001; if_addr = 32'h100; if_req = 1'b1; t0 = cyc;
    @(negedge clk); check("t1 idle en", mem_en, 0);
    @(negedge clk); check("t1 c1 en", mem_en, 1); check("t1 c1 addr", mem_addr, 32'h100);
    @(negedge clk); check("t1 c2 en", mem_en, 1); check("t1 c2 addr", mem_addr, 32'h100);
    @(negedge clk); check("t1 c3 if_ack", if_ack, 1); check("t1 c3 en", mem_en, 0);
    @(posedge clk); #1 if_req = 1'b0;
    @(negedge clk); check("t1 if_rdata", if_rdata, 32'hE3A0_0001);

    // Load then store: store must leave d_rdata alone
    @(posedge clk); #1;
    rd_fixed = 32'h1234_5678; d_addr = 32'h80; d_we = 1'b0; d_req = 1'b1;
    wait_ack(1'b1, at);
    @(posedge clk); #1 d_req = 1'b0;
    @(posedge clk); #1;
    d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h55; d_req = 1'b1; t0 = cyc;
    @(negedge clk);
    @(negedge clk); check("t2 c1 we", mem_we, 1); check("t2 c1 addr", mem_addr, 32'h40);
    check("t2 c1 wdata", mem_wdata, 32'h55);
    @(negedge clk); check("t2 c2 we", mem_we, 1); check("t2 c2 wdata", mem_wdata, 32'h55);
    @(negedge clk); check("t2 c3 d_ack", d_ack, 1);
    @(posedge clk); #1 d_req = 1'b0; d_we = 1'b0;
    @(negedge clk); check("t2 d_rdata kept", d_rdata, 32'h1234_5678);

    // Simultaneous requests right after reset: fetch first, acks 4 apart
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    if_addr = 32'h200; d_addr = 32'h300; t0 = cyc;
    contend(2);
    if (ack_port_q.size() >= 2) begin
      check("t3 first is fetch", ack_port_q[0], 0);
      check("t3 second is data", ack_port_q[1], 1);
      check("t3 first ack latency", ack_cyc_q[0] - t0, 3);
      check("t3 ack spacing", ack_cyc_q[1] - ack_cyc_q[0], 4);
    end

    // Continuous contention, four transfers
    vary = 1'b1;
    @(posedge clk); #1;
    contend(4);
    for (int i = 0; i < 4; i++) begin
      if (i < ack_port_q.size()) check("t4 grant order", ack_port_q[i], exp_order[i]);
      if (i > 0 && i < ack_cyc_q.size()) check("t4 spacing", ack_cyc_q[i] - ack_cyc_q[i-1], 4);
    end

    // Reset in the second busy cycle of a load
    @(posedge clk); #1;
    d_we = 1'b0; d_addr = 32'h90; d_req = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
    #1 check("t5 en abort", mem_en, 0);
    @(posedge clk); #1 rst = 1'b1;
    wait_ack(1'b1, at);
    check("t5 reack cycle", at - t0, 6);
    @(posedge clk); #1 d_req = 1'b0;

    // if_addr changes while busy
    @(posedge clk); #1;
    if_addr = 32'h500; if_req = 1'b1;
    @(posedge clk); #1 if_addr = 32'h600;
    @(negedge clk); check("t6 c1 addr", mem_addr, 32'h500);
    @(posedge clk); #1;
    @(negedge clk); check("t6 c2 addr", mem_addr, 32'h500);
    wait_ack(1'b0, at);
    @(posedge clk); #1 if_req = 1'b0;

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter LAT, default 2, meaning memory access cycles per transfer; legal range 1..15.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 if_req  in  1  instruction-fetch request; held high until if_ack.
REQ-005 if_addr  in  32  fetch address.
REQ-006 if_ack  out  1  one-cycle fetch completion pulse.
REQ-007 if_rdata  out  32  fetched word.
REQ-008 d_req  in  1  data (LDR/STR) request; held high until d_ack.
REQ-009 d_we  in  1  1=store, 0=load.
REQ-010 d_addr  in  32  data address.
REQ-011 d_wdata  in  32  store data.
REQ-012 d_ack  out  1  one-cycle data completion pulse.
REQ-013 d_rdata  out  32  load data.
REQ-014 mem_en  out  1  memory access strobe.
REQ-015 mem_we  out  1  memory write enable.
REQ-016 mem_addr  out  32  memory address.
REQ-017 mem_wdata  out  32  memory write data.
REQ-018 mem_rdata  in  32  memory read data, valid in last cycle of mem_en.

Function
REQ-019 States SHALL be IDLE, BUSY, RESP; a 1-bit owner register (0=fetch, 1=data) and a 1-bit last-grant register SHALL exist.
REQ-020 IDLE: only d_req -> grant data; only if_req -> grant fetch; both -> grant the port not in last-grant; neither -> stay IDLE.
REQ-021 On grant the block SHALL latch address, we (fetch: we=0) and wdata of the granted port, load counter with LAT-1, set owner and last-grant, enter BUSY.
REQ-022 BUSY: mem_en=1, mem_we/mem_addr/mem_wdata driven from latched values only; requester input changes SHALL be ignored.
REQ-023 BUSY: counter decrements each cycle; at counter 0 the block SHALL capture mem_rdata into the owner's rdata register (loads/fetches only) and enter RESP.
REQ-024 RESP: owner's ack=1 for exactly one cycle, mem_en=0, next state IDLE; req inputs SHALL NOT be sampled in RESP.
REQ-025 Latency: request sampled in IDLE cycle N -> ack in cycle N+LAT+1; mem_en high cycles N+1..N+LAT.
REQ-026 Stores SHALL leave d_rdata unchanged; if_rdata/d_rdata SHALL hold until overwritten by a later read on that port.
REQ-027 if_ack and d_ack SHALL never be high together; mem_we SHALL be 0 whenever mem_en is 0.
REQ-028 Continuous contention SHALL alternate grants fetch/data with no port waiting more than one transfer.
REQ-029 Counter SHALL be 4 bits; no wrap-around occurs for legal LAT.

Reset
REQ-030 rst low SHALL immediately force IDLE, counter 0, owner 0, last-grant 1 (first tie goes to fetch), all outputs and rdata registers 0.
REQ-031 Reset during BUSY or RESP SHALL abort the transfer with no ack; after release, pending req is re-arbitrated from IDLE.

Verification
REQ-032 LAT=2, if_req, if_addr=0x100, mem_rdata=0xE3A00001 -> mem_en cycles 1-2 at 0x100, if_ack cycle 3, if_rdata=0xE3A00001.
REQ-033 d_req store, d_addr=0x40, d_wdata=0x55 -> mem_we=1, mem_addr=0x40, mem_wdata=0x55 for 2 cycles, d_ack cycle 3, d_rdata unchanged.
REQ-034 if_req and d_req together after reset -> fetch served first, then data; acks 4 cycles apart, never overlapping.
REQ-035 Both held continuously for 4 transfers -> grant order F,D,F,D.
REQ-036 rst low in second BUSY cycle of a load -> mem_en 0 at once, no d_ack; re-request after release completes normally.
REQ-037 if_addr changed mid-BUSY -> mem_addr keeps latched value.
